orion_ps2_kbd_matrix: RTL and testbench

- Keyboard-side responder to the i8255 keyboard scan performed by the CPU.
- Receives PS/2 frames, tracks make/break state in an 8x8 Orion key matrix plus three modifier keys.
- Answers the PPI column scan: port A output is the column select; port B input is the row data; port C[7:5] inputs are the modifiers.
- Sits beside u_kbd_io in orion_pro_top and drives kbd_input from kbd_output.

---
 rtl/orion_kbd_pkg.sv | 60 ++++++
 rtl/orion_ps2_kbd_matrix_ps2_rx_frame.sv | 113 +++++++++++
 rtl/orion_ps2_kbd_matrix.sv | 127 ++++++++++++
 tb/tb_orion_ps2_kbd_matrix.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/orion_kbd_pkg.sv
// rtl/orion_kbd_pkg.sv - shared types, PS/2 constants and the Orion keymap
package orion_kbd_pkg;

  typedef struct packed {
    logic       valid;
    logic       is_mod;
    logic [2:0] col;
    logic [2:0] row;
  } kbd_key_t;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  localparam logic [7:0] PS2_E0  = 8'hE0;
  localparam logic [7:0] PS2_F0  = 8'hF0;
  localparam logic [7:0] PS2_BAT = 8'hAA;
  localparam logic [7:0] PS2_ACK = 8'hFA;

  localparam int MOD_SS   = 0;
  localparam int MOD_CTRL = 1;
  localparam int MOD_RUS  = 2;

  function automatic kbd_key_t mk(input int c, input int r);
    return {1'b1, 1'b0, c[2:0], r[2:0]};
  endfunction

  // Modifier entries reuse row as the modifier index and col as the instance (left/right).
  function automatic kbd_key_t mm(input int idx, input int inst);
    return {1'b1, 1'b1, inst[2:0], idx[2:0]};
  endfunction

  // Lookup key is {ext, scancode}; anything not listed is unmapped.
  function automatic kbd_key_t kbd_keymap(input logic [8:0] code);
    kbd_key_t k;
    k = '0;
    case (code)
      9'h16C: k = mk(0, 0);  9'h005: k = mk(0, 1);  9'h006: k = mk(0, 2);  9'h004: k = mk(0, 3);
      9'h00C: k = mk(0, 4);  9'h16B: k = mk(0, 5);  9'h174: k = mk(0, 6);  9'h175: k = mk(0, 7);
      9'h00D: k = mk(1, 0);  9'h066: k = mk(1, 1);  9'h05A: k = mk(1, 2);  9'h172: k = mk(1, 3);
      9'h076: k = mk(1, 4);  9'h045: k = mk(1, 5);  9'h016: k = mk(1, 6);  9'h01E: k = mk(1, 7);
      9'h026: k = mk(2, 0);  9'h01C: k = mk(2, 1);  9'h032: k = mk(2, 2);  9'h021: k = mk(2, 3);
      9'h023: k = mk(2, 4);  9'h024: k = mk(2, 5);  9'h02B: k = mk(2, 6);  9'h034: k = mk(2, 7);
      9'h033: k = mk(3, 0);  9'h043: k = mk(3, 1);  9'h03B: k = mk(3, 2);  9'h042: k = mk(3, 3);
      9'h04B: k = mk(3, 4);  9'h03A: k = mk(3, 5);  9'h031: k = mk(3, 6);  9'h044: k = mk(3, 7);
      9'h04D: k = mk(4, 0);  9'h015: k = mk(4, 1);  9'h02D: k = mk(4, 2);  9'h01B: k = mk(4, 3);
      9'h02C: k = mk(4, 4);  9'h03C: k = mk(4, 5);  9'h02A: k = mk(4, 6);  9'h01D: k = mk(4, 7);
      9'h022: k = mk(5, 0);  9'h035: k = mk(5, 1);  9'h01A: k = mk(5, 2);  9'h025: k = mk(5, 3);
      9'h02E: k = mk(5, 4);  9'h036: k = mk(5, 5);  9'h03D: k = mk(5, 6);  9'h03E: k = mk(5, 7);
      9'h046: k = mk(6, 0);  9'h04E: k = mk(6, 1);  9'h055: k = mk(6, 2);  9'h041: k = mk(6, 3);
      9'h049: k = mk(6, 4);  9'h04A: k = mk(6, 5);  9'h04C: k = mk(6, 6);  9'h052: k = mk(6, 7);
      9'h029: k = mk(7, 0);  9'h054: k = mk(7, 1);  9'h05B: k = mk(7, 2);  9'h05D: k = mk(7, 3);
      9'h00E: k = mk(7, 4);  9'h170: k = mk(7, 5);  9'h17D: k = mk(7, 6);  9'h17A: k = mk(7, 7);
      9'h012: k = mm(MOD_SS, 0);    9'h059: k = mm(MOD_SS, 1);
      9'h014: k = mm(MOD_CTRL, 0);  9'h114: k = mm(MOD_CTRL, 1);
      9'h058: k = mm(MOD_RUS, 0);
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/orion_ps2_kbd_matrix_ps2_rx_frame.sv
// rtl/orion_ps2_kbd_matrix_ps2_rx_frame.sv - PS/2 synchroniser, frame FSM and timeout
module ps2_rx_frame
  import orion_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_code_stb,
  output logic [7:0] o_code,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   fall, dat;
  rx_state_t              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   stb_d, err_d, timeout;

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign dat    = dat_sync[SYNC_STAGES-1];
  assign o_code = shift_q;

  // Synchronise both PS/2 lines; idle-high reset value avoids a false edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], i_ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  // Frame state and registered strobes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      o_code_stb  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      o_code_stb  <= stb_d;
      o_frame_err <= err_d;
    end
  end

  // Next state: one transition per falling edge; a stalled frame is dropped at the timeout.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    stb_d     = 1'b0;
    err_d     = 1'b0;
    timeout   = (state_q != RX_IDLE) && (tmo_q == TMO_MAX);
    if (state_q == RX_IDLE || fall) tmo_d = '0;
    else if (!timeout)              tmo_d = tmo_q + TW'(1);
    else                            tmo_d = tmo_q;
    if (timeout) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        RX_DATA: begin
          shift_d = {dat, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
        RX_PARITY: begin
          par_d   = dat;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (dat && (^{shift_q, par_q})) stb_d = 1'b1;
          else                            err_d = 1'b1;
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/orion_ps2_kbd_matrix.sv
// rtl/orion_ps2_kbd_matrix.sv - PS/2 to Orion 8x8 key matrix responder (optional KBD_RESET_KEY_EN)
module orion_ps2_kbd_matrix
  import orion_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic [7:0] i_col_sel,
  output logic [7:0] o_rows,
  output logic [2:0] o_mods,
  output logic       o_frame_err,
  output logic       o_reset_req
);

  logic            rx_stb;
  logic [7:0]      rx_code;
  logic [7:0][7:0] matrix_q, matrix_d;   // [col][row]
  logic [5:0]      mod_q, mod_d;         // {index, instance}
  logic            ext_q, ext_d, brk_q, brk_d;
  logic            code_key;             // strobe carries a non-prefix key code
  logic [2:0]      mod_idx;
  kbd_key_t        key;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_rx (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .o_code_stb  (rx_stb),
    .o_code      (rx_code),
    .o_frame_err (o_frame_err)
  );

  assign key      = kbd_keymap({ext_q, rx_code});
  assign mod_idx  = {key.row[1:0], key.col[0]};
  assign code_key = rx_stb && rx_code != PS2_E0 && rx_code != PS2_F0 &&
                    rx_code != PS2_BAT && rx_code != PS2_ACK;

  // Decode: prefixes arm flags, key codes set or clear their bit, then flags drop.
  always_comb begin
    matrix_d = matrix_q;
    mod_d    = mod_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    if (rx_stb && rx_code == PS2_E0) ext_d = 1'b1;
    if (rx_stb && rx_code == PS2_F0) brk_d = 1'b1;
    if (code_key) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
      if (key.valid && key.is_mod) mod_d[mod_idx] = ~brk_q;
      else if (key.valid)          matrix_d[key.col][key.row] = ~brk_q;
    end
  end

  // Key state registers and the registered, active-low modifier port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      matrix_q <= '0;
      mod_q    <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      o_mods   <= 3'b111;
    end else begin
      matrix_q <= matrix_d;
      mod_q    <= mod_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      o_mods[MOD_SS]   <= ~|mod_q[2*MOD_SS   +: 2];
      o_mods[MOD_CTRL] <= ~|mod_q[2*MOD_CTRL +: 2];
      o_mods[MOD_RUS]  <= ~|mod_q[2*MOD_RUS  +: 2];
    end
  end

  // Scan response: a row reads low if any selected column has a key down in it.
  always_comb begin
    o_rows = 8'hFF;
    for (int c = 0; c < 8; c++) begin
      if (!i_col_sel[c]) o_rows = o_rows & ~matrix_q[c];
    end
  end

`ifdef KBD_RESET_KEY_EN
  logic [1:0] alt_q, alt_d;
  logic       del_q, del_d, armed_q, armed_d, rreq_d, trio_make;

  // Ctrl-Alt-Del: fire on the make that completes the chord, re-arm once all are up.
  always_comb begin
    alt_d     = alt_q;
    del_d     = del_q;
    armed_d   = armed_q;
    rreq_d    = 1'b0;
    trio_make = 1'b0;
    if (code_key && rx_code == 8'h11) alt_d[ext_q] = ~brk_q;
    if (code_key && ext_q && rx_code == 8'h71) del_d = ~brk_q;
    if (code_key && !brk_q)
      trio_make = (rx_code == 8'h11) || (ext_q && rx_code == 8'h71) ||
                  (key.valid && key.is_mod && key.row == 3'(MOD_CTRL));
    if (trio_make && armed_q && (|mod_d[2*MOD_CTRL +: 2]) && (|alt_d) && del_d) begin
      rreq_d  = 1'b1;
      armed_d = 1'b0;
    end
    if (!(|mod_d[2*MOD_CTRL +: 2]) && !(|alt_d) && !del_d) armed_d = 1'b1;
  end

  // Chord tracking state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alt_q       <= '0;
      del_q       <= 1'b0;
      armed_q     <= 1'b1;
      o_reset_req <= 1'b0;
    end else begin
      alt_q       <= alt_d;
      del_q       <= del_d;
      armed_q     <= armed_d;
      o_reset_req <= rreq_d;
    end
  end
`else
  assign o_reset_req = 1'b0;
`endif

endmodule

// File: tb/tb_orion_ps2_kbd_matrix.sv
// tb/tb_orion_ps2_kbd_matrix.sv - directed bench with a received-code scoreboard
module tb_orion_ps2_kbd_matrix;

`ifdef KBD_RESET_KEY_EN
  localparam int RK = 1;
`else
  localparam int RK = 0;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_ps2_clk = 1'b1;
  logic       i_ps2_data = 1'b1;
  logic [7:0] i_col_sel = 8'h00;
  logic [7:0] o_rows;
  logic [2:0] o_mods;
  logic       o_frame_err, o_reset_req;

  int         checks = 0;
  int         failures = 0;
  int         err_cnt = 0;
  int         rreq_cnt = 0;
  int         stb_cnt = 0;
  int         exp_stb = 0;
  logic [7:0] last_code = 8'h00;
  logic [7:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  orion_ps2_kbd_matrix #(.TIMEOUT_CYCLES(300), .SYNC_STAGES(2)) u_dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_ps2_clk   (i_ps2_clk),
    .i_ps2_data  (i_ps2_data),
    .i_col_sel   (i_col_sel),
    .o_rows      (o_rows),
    .o_mods      (o_mods),
    .o_frame_err (o_frame_err),
    .o_reset_req (o_reset_req)
  );

  always @(negedge i_clk) begin
    if (o_frame_err) err_cnt <= err_cnt + 1;
    if (o_reset_req) rreq_cnt <= rreq_cnt + 1;
    if (u_dut.rx_stb) begin
      stb_cnt   <= stb_cnt + 1;
      last_code <= u_dut.rx_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge i_clk);
    i_ps2_data = b;
    repeat (5) @(negedge i_clk);
    i_ps2_clk = 1'b0;
    repeat (10) @(negedge i_clk);
    i_ps2_clk = 1'b1;
    repeat (5) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par = 0, input int nbits = 11);
    logic [10:0] bits;
    logic [7:0]  e;
    bit          valid;
    bits  = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    valid = (nbits == 11) && !bad_par;
    if (valid) begin
      exp_q.push_back(code);
      exp_stb++;
    end
    for (int i = 0; i < nbits; i++) send_bit(bits[i]);
    i_ps2_data = 1'b1;
    repeat (10) @(negedge i_clk);
    check($sformatf("strobe_count_%02h", code), stb_cnt, exp_stb);
    if (valid) begin
      e = exp_q.pop_front();
      check($sformatf("rx_code_%02h", code), last_code, e);
    end
  endtask

  task automatic rows_is(input string tag, input logic [7:0] sel, input logic [7:0] exp);
    i_col_sel = sel;
    @(negedge i_clk);
    check(tag, o_rows, exp);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("reset_rows", o_rows, 8'hFF);
    check("reset_mods", o_mods, 3'b111);
    check("reset_err", o_frame_err, 1'b0);
    check("reset_rreq", o_reset_req, 1'b0);

    send_frame(8'h1C);
    rows_is("a_col2", 8'hFB, 8'hFD);
    rows_is("a_col0", 8'hFE, 8'hFF);
    rows_is("a_nosel", 8'hFF, 8'hFF);
    send_frame(8'hF0); send_frame(8'h1C);
    rows_is("a_break", 8'hFB, 8'hFF);
    check("no_err_clean", err_cnt, 0);

    send_frame(8'hE0); send_frame(8'h75); send_frame(8'h29);
    rows_is("up_space", 8'h7E, 8'h7E);
    send_frame(8'hF0); send_frame(8'h29);
    rows_is("space_break", 8'h7E, 8'h7F);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    rows_is("up_break", 8'h00, 8'hFF);

    send_frame(8'h12);
    check("mods_shift", o_mods, 3'b110);
    send_frame(8'h58);
    check("mods_shift_rus", o_mods, 3'b010);
    send_frame(8'hF0); send_frame(8'h12);
    check("mods_rus", o_mods, 3'b011);
    send_frame(8'hF0); send_frame(8'h58);
    check("mods_none", o_mods, 3'b111);

    send_frame(8'h5A); send_frame(8'h5A);
    rows_is("enter_typematic", 8'hFD, 8'hFB);
    send_frame(8'hF0); send_frame(8'h5A);
    rows_is("enter_break", 8'hFD, 8'hFF);

    send_frame(8'h1C, 1);
    check("parity_err", err_cnt, 1);
    rows_is("parity_nochange", 8'hFB, 8'hFF);

    send_frame(8'h1C, 0, 4);
    repeat (400) @(negedge i_clk);
    check("timeout_err", err_cnt, 2);
    rows_is("timeout_nochange", 8'hFB, 8'hFF);

    send_frame(8'h5A);
    rows_is("enter_before_reset", 8'hFD, 8'hFB);
    send_frame(8'h1C, 0, 5);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (400) @(negedge i_clk);
    check("reset_midframe_err", err_cnt, 2);
    rows_is("reset_cleared", 8'h00, 8'hFF);
    send_frame(8'h1C);
    rows_is("a_after_reset", 8'hFB, 8'hFD);
    send_frame(8'hF0); send_frame(8'h1C);

    send_frame(8'h14); send_frame(8'h11); send_frame(8'hE0); send_frame(8'h71);
    check("ctrl_mod", o_mods, 3'b101);
    check("cad_first", rreq_cnt, RK);
    send_frame(8'hE0); send_frame(8'h71);
    check("cad_repeat", rreq_cnt, RK);
    send_frame(8'hF0); send_frame(8'h14); send_frame(8'hF0); send_frame(8'h11);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h71);
    check("cad_released", rreq_cnt, RK);
    send_frame(8'h14); send_frame(8'h11); send_frame(8'hE0); send_frame(8'h71);
    check("cad_second", rreq_cnt, 2 * RK);
    send_frame(8'hF0); send_frame(8'h14);
    check("ctrl_release", o_mods, 3'b111);
    check("final_err", err_cnt, 2);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
